fetch_unit: RTL and testbench

// Instruction-fetch front end feeding decode/register-file/ALU. Keeps a PC, issues

---
 rtl/fetch_if.sv | 27 ++
 rtl/fetch_unit.sv | 99 +++++++++
 tb/tb_fetch_unit.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/fetch_if.sv
// Fetch-unit bus bundle: instruction-memory request/response channels,
// decode-side instruction channel, and the branch redirect input.
interface fetch_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
           redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
           redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC generation, credit-limited word fetches,
// DEPTH-entry prefetch FIFO, and redirect flush with squash of in-flight responses.
module fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input logic    clk,
  input logic    rst,
  fetch_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  // Headroom above DEPTH: squashed requests stack up across repeated redirects
  // until the memory returns them.
  localparam int CW = AW + 4;

  logic [31:0]   fetch_pc;
  logic [31:0]   rsp_pc;
  logic [CW-1:0] inflight;
  logic [CW-1:0] discard;
  logic [CW-1:0] count;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          run;

  logic [31:0]   fifo_data [DEPTH];
  logic [31:0]   fifo_pc   [DEPTH];

  logic          redir;
  logic          rsp;
  logic          keep;
  logic          accept;
  logic          pop;
  logic          req_valid;
  logic          out_valid;
  logic [CW-1:0] occupancy;
  logic [31:0]   redir_pc_aligned;
  logic          unused_redir_lsb;

  assign redir            = bus.redirect_valid;
  assign rsp              = bus.imem_rsp_valid;
  assign redir_pc_aligned = {bus.redirect_pc[31:2], 2'b00};
  assign unused_redir_lsb = ^bus.redirect_pc[1:0];

  // Buffered plus live in-flight words; squashed requests hold no FIFO credit.
  assign occupancy = count + inflight - discard;
  assign req_valid = run && !redir && (occupancy < CW'(DEPTH));
  assign accept    = req_valid && bus.imem_req_ready;
  assign keep      = rsp && !redir && (discard == '0);
  assign out_valid = (count != '0) && !redir;
  assign pop       = out_valid && bus.instr_ready;

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc;
  assign bus.instr_valid    = out_valid;
  assign bus.instr          = (count != '0) ? fifo_data[rd_ptr] : 32'h0;
  assign bus.instr_pc       = (count != '0) ? fifo_pc[rd_ptr]   : 32'h0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run      <= 1'b0;
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      inflight <= '0;
      discard  <= '0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      run <= 1'b1;
      if (redir) begin
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        fetch_pc <= redir_pc_aligned;
        rsp_pc   <= redir_pc_aligned;
        inflight <= inflight - CW'(rsp);
        discard  <= inflight - CW'(rsp);
      end else begin
        if (accept) fetch_pc <= fetch_pc + 32'd4;
        inflight <= inflight + CW'(accept) - CW'(rsp);
        if (rsp && (discard != '0)) discard <= discard - 1'b1;
        if (keep) begin
          wr_ptr <= wr_ptr + 1'b1;
          rsp_pc <= rsp_pc + 32'd4;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        count <= count + CW'(keep) - CW'(pop);
      end
    end
  end

  // FIFO storage carries data only; validity lives in count.
  always_ff @(posedge clk) begin
    if (keep) begin
      fifo_data[wr_ptr] <= bus.imem_rsp_data;
      fifo_pc[wr_ptr]   <= rsp_pc;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: memory model with in-order responses and a
// queue-based reference of outstanding fetches and buffered instructions.
module tb_fetch_unit;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_if bus ();

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct { logic [31:0] addr; bit live; } req_t;
  typedef struct { logic [31:0] data; logic [31:0] pc; } ins_t;

  req_t        pend[$];
  ins_t        exp_q[$];
  logic [31:0] m_pc;
  bit          started;
  int          n_checks = 0;
  int          n_errs   = 0;
  int          acc_total;
  int          acc_one;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  function automatic int live_cnt();
    int n = 0;
    foreach (pend[i]) if (pend[i].live) n++;
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Called at posedge+1; drives one cycle, checks, advances the model, returns at next posedge+1.
  task automatic step(input int p_rdy, input int p_rsp, input int p_irdy, input int p_redir,
                      input logic [31:0] rpc, output int acc_seen);
    bit   want_rv, want_iv, rdy, irdy, rdr, rv;
    ins_t ins;
    req_t r;
    rdy  = ($urandom_range(99) < p_rdy);
    irdy = ($urandom_range(99) < p_irdy);
    rdr  = ($urandom_range(99) < p_redir);
    rv   = (pend.size() > 0) && ($urandom_range(99) < p_rsp);
    bus.imem_req_ready = rdy;
    bus.instr_ready    = irdy;
    bus.redirect_valid = rdr;
    bus.redirect_pc    = rpc;
    bus.imem_rsp_valid = rv;
    bus.imem_rsp_data  = rv ? mem_word(pend[0].addr) : $urandom;
    #1;
    want_rv = started && !rdr && ((exp_q.size() + live_cnt()) < DEPTH);
    want_iv = (exp_q.size() != 0) && !rdr;
    chk("req_valid", bus.imem_req_valid, want_rv);
    if (want_rv) chk("req_addr", bus.imem_req_addr, m_pc);
    chk("instr_valid", bus.instr_valid, want_iv);
    if (want_iv) begin
      chk("instr", bus.instr, exp_q[0].data);
      chk("instr_pc", bus.instr_pc, exp_q[0].pc);
    end
    acc_seen = (bus.imem_req_valid && bus.imem_req_ready) ? 1 : 0;
    if (rdr) begin
      exp_q.delete();
      if (rv) void'(pend.pop_front());
      foreach (pend[i]) pend[i].live = 1'b0;
      m_pc = {rpc[31:2], 2'b00};
    end else begin
      if (want_iv && irdy) void'(exp_q.pop_front());
      if (rv) begin
        r = pend.pop_front();
        if (r.live) begin
          ins.data = mem_word(r.addr);
          ins.pc   = r.addr;
          exp_q.push_back(ins);
        end
      end
      if (want_rv && rdy) begin
        r.addr = m_pc;
        r.live = 1'b1;
        pend.push_back(r);
        m_pc = m_pc + 32'd4;
      end
    end
    started = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.imem_req_ready = 1'b0;
    bus.instr_ready    = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    rst = 1'b0;
    #1;
    chk("rst_req_valid", bus.imem_req_valid, 1'b0);
    chk("rst_req_addr", bus.imem_req_addr, RESET_PC);
    chk("rst_instr_valid", bus.instr_valid, 1'b0);
    chk("rst_instr", bus.instr, 32'h0);
    chk("rst_instr_pc", bus.instr_pc, 32'h0);
    pend.delete();
    exp_q.delete();
    m_pc    = RESET_PC;
    started = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Streaming with an always-ready 1-cycle memory and decode.
    repeat (30) step(100, 100, 100, 0, 32'h0, acc_one);

    // Decode stalled: only DEPTH live fetches may be accepted.
    step(100, 100, 100, 100, 32'h0000_0200, acc_one);
    acc_total = 0;
    repeat (20) begin
      step(100, 100, 0, 0, 32'h0, acc_one);
      acc_total += acc_one;
    end
    chk("accepts_when_stalled", acc_total, DEPTH);
    repeat (10) step(100, 100, 100, 0, 32'h0, acc_one);

    // Two fetches outstanding, then redirect to an unaligned target.
    step(100, 100, 100, 100, 32'h0000_0040, acc_one);
    repeat (2) step(100, 0, 100, 0, 32'h0, acc_one);
    step(0, 100, 100, 100, 32'h0000_0103, acc_one);
    repeat (15) step(100, 100, 100, 0, 32'h0, acc_one);

    // Address wrap past the top of the address space, with stalls.
    step(100, 100, 100, 100, 32'hFFFF_FFF6, acc_one);
    repeat (25) step(50, 70, 70, 0, 32'h0, acc_one);

    // Randomized traffic with occasional redirects.
    repeat (400) step(60, 50, 60, 6, $urandom, acc_one);
    repeat (150) step(90, 90, 30, 10, $urandom, acc_one);

    // Asynchronous reset in the middle of a burst.
    repeat (8) step(100, 60, 80, 0, 32'h0, acc_one);
    do_reset();
    repeat (200) step(70, 60, 70, 4, $urandom, acc_one);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
